// File: rtl/dvp_pattern_src.sv
// dvp_pattern_src
// ---------------
// Emulates an OV5640 DVP output in RGB565 mode so the capture -> FIFO ->
// SDRAM -> VGA path can run without a sensor. One byte per sys_clk cycle,
// two bytes per pixel, high byte first. Every pattern is an exact,
// predictable function of pixel position and frame number.
//
// Ports:
//   sys_clk      generator clock, also the pixel/byte clock
//   sys_rst      asynchronous, active-high reset
//   gen_en       run request, only looked at on frame boundaries
//   pattern_sel  0 colour bars, 1 pixel counter, 2 checkerboard,
//                3 frame-tinted solid (latched at each frame start)
//   dvp_vsync    frame sync, active high
//   dvp_href     line valid, active high
//   dvp_data     RGB565 byte stream, 0 whenever dvp_href is low
//   frame_start  one-cycle pulse on the first vsync-high cycle
//   frame_cnt    frames started since reset, wraps at 65535 -> 0
//   busy         high in every state except IDLE
//
// Handshake: there is no back-pressure. A byte is valid exactly in the cycles
// where dvp_href is high; the sink must take it in that cycle.
//
// All state counters are 16 bits wide; every timing parameter and 2*H_PIXEL
// must fit in that range. H_PIXEL must be a multiple of 8.

module dvp_pattern_src #(
  parameter int H_PIXEL     = 640,
  parameter int V_PIXEL     = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_CYC   = 1600,
  parameter int V_BACK_CYC  = 3200,
  parameter int V_FRONT_CYC = 1600
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        gen_en,
  input  logic [1:0]  pattern_sel,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_LINE, S_HBLANK, S_VFRONT
  } state_t;

  localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_CYC - 1);
  localparam logic [15:0] VBACK_LAST  = 16'(V_BACK_CYC - 1);
  localparam logic [15:0] LINE_LAST   = 16'(2 * H_PIXEL - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VFRONT_LAST = 16'(V_FRONT_CYC - 1);
  localparam logic [15:0] BAR_LAST    = 16'(H_PIXEL / 8 - 1);
  // py counts completed lines, so it equals V_PIXEL during the last HBLANK.
  localparam logic [15:0] Y_END       = 16'(V_PIXEL);

  state_t      state;
  logic [15:0] cnt;       // cycles spent in the current state
  logic [1:0]  pat;       // pattern latched at frame start
  // Position of the NEXT byte to be emitted, so the registered output can
  // carry the first byte in the same cycle href rises.
  logic [15:0] px;
  logic [15:0] py;
  logic        ph;        // 0 = high byte, 1 = low byte
  logic [15:0] pidx;      // running pixel index for the counter pattern
  logic [15:0] bar_cnt;   // pixels emitted in the current colour bar
  logic [2:0]  bar_idx;

  logic        start;     // a frame starts at the coming edge
  logic        emit;      // a data byte is driven after the coming edge
  logic [15:0] pix;
  logic [7:0]  next_byte;

  always_comb begin
    start = gen_en && ((state == S_IDLE) ||
                       (state == S_VFRONT && cnt == VFRONT_LAST));
    emit  = (state == S_VBACK  && cnt == VBACK_LAST) ||
            (state == S_LINE   && cnt != LINE_LAST)  ||
            (state == S_HBLANK && cnt == HBLANK_LAST && py != Y_END);
  end

  always_comb begin
    pix = 16'h0000;
    case (pat)
      2'd0: begin
        case (bar_idx)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = pidx;
      2'd2:    pix = (px[5] ^ py[5]) ? 16'hFFFF : 16'h0000;
      default: pix = {frame_cnt[4:0], 11'd0};
    endcase
    next_byte = ph ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pat         <= '0;
      px          <= '0;
      py          <= '0;
      ph          <= 1'b0;
      pidx        <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      dvp_vsync   <= 1'b0;
      dvp_href    <= 1'b0;
      dvp_data    <= 8'h00;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
    end else begin
      // Control flow
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_VSYNC;
            cnt   <= '0;
          end
        end
        S_VSYNC: begin
          if (cnt == VSYNC_LAST) begin
            state <= S_VBACK;
            cnt   <= '0;
          end else cnt <= cnt + 16'd1;
        end
        S_VBACK: begin
          if (cnt == VBACK_LAST) begin
            state <= S_LINE;
            cnt   <= '0;
          end else cnt <= cnt + 16'd1;
        end
        S_LINE: begin
          if (cnt == LINE_LAST) begin
            state <= S_HBLANK;
            cnt   <= '0;
          end else cnt <= cnt + 16'd1;
        end
        S_HBLANK: begin
          if (cnt == HBLANK_LAST) begin
            state <= (py == Y_END) ? S_VFRONT : S_LINE;
            cnt   <= '0;
          end else cnt <= cnt + 16'd1;
        end
        S_VFRONT: begin
          if (cnt == VFRONT_LAST) begin
            state <= start ? S_VSYNC : S_IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 16'd1;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase

      // Registered outputs reflect the state being entered.
      frame_start <= start;
      dvp_vsync   <= start || (state == S_VSYNC && cnt != VSYNC_LAST);
      dvp_href    <= emit;
      dvp_data    <= emit ? next_byte : 8'h00;
      busy        <= start ||
                     !((state == S_IDLE) ||
                       (state == S_VFRONT && cnt == VFRONT_LAST));

      // Pixel position / pattern datapath
      if (start) begin
        frame_cnt <= frame_cnt + 16'd1;
        pat       <= pattern_sel;
        px        <= '0;
        py        <= '0;
        ph        <= 1'b0;
        pidx      <= '0;
        bar_cnt   <= '0;
        bar_idx   <= '0;
      end else if (emit) begin
        ph <= ~ph;
        if (ph) begin
          px   <= px + 16'd1;
          pidx <= pidx + 16'd1;
          if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else bar_cnt <= bar_cnt + 16'd1;
        end
      end else if (state == S_LINE && cnt == LINE_LAST) begin
        // Line finished: rewind the column and move to the next line now,
        // so the first byte of the next line is ready when HBLANK ends.
        px      <= '0;
        ph      <= 1'b0;
        bar_cnt <= '0;
        bar_idx <= '0;
        py      <= py + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_pattern_src.sv
// Testbench for dvp_pattern_src with a small frame geometry.
module tb_dvp_pattern_src;

  localparam int H_PIXEL     = 8;
  localparam int V_PIXEL     = 4;
  localparam int H_BLANK     = 4;
  localparam int VSYNC_CYC   = 3;
  localparam int V_BACK_CYC  = 2;
  localparam int V_FRONT_CYC = 2;
  localparam int FRAME_LEN   = VSYNC_CYC + V_BACK_CYC +
                               V_PIXEL * (2 * H_PIXEL + H_BLANK) + V_FRONT_CYC;

  localparam logic [15:0] BAR_COL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        gen_en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        busy;

  always #5 sys_clk = ~sys_clk;

  dvp_pattern_src #(
    .H_PIXEL(H_PIXEL), .V_PIXEL(V_PIXEL), .H_BLANK(H_BLANK),
    .VSYNC_CYC(VSYNC_CYC), .V_BACK_CYC(V_BACK_CYC), .V_FRONT_CYC(V_FRONT_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gen_en(gen_en),
    .pattern_sel(pattern_sel), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
    .dvp_data(dvp_data), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          model_fcnt = 0;
  int          fs_total = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: pixel value from position and frame number.
  function automatic logic [15:0] ref_pix(input int sel, input int x,
                                          input int y, input int fc);
    case (sel)
      0:       return BAR_COL[x / (H_PIXEL / 8)];
      1:       return 16'((y * H_PIXEL + x) % 65536);
      2:       return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
      default: return 16'((fc % 32) * 2048);
    endcase
  endfunction

  task automatic push_frame(input int sel, input int fc);
    logic [15:0] p;
    for (int y = 0; y < V_PIXEL; y++)
      for (int x = 0; x < H_PIXEL; x++) begin
        p = ref_pix(sel, x, y, fc);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
  endtask

  // ---------------- monitor ----------------
  int vs_len = 0, h_len = 0, lines = 0, fs_cyc = 0, fall_cyc = 0;
  bit in_frame = 1'b0;

  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      vs_len = 0; h_len = 0; lines = 0; in_frame = 1'b0;
    end else begin
      if (frame_start) begin
        if (in_frame) begin
          check("lines_per_frame", 32'(lines), 32'(V_PIXEL));
          check("frame_spacing", 32'(cyc - fs_cyc), 32'(FRAME_LEN));
        end
        model_fcnt = (model_fcnt + 1) % 65536;
        fs_total++;
        check("frame_cnt_at_start", 32'(frame_cnt), 32'(model_fcnt));
        check("vsync_at_start", 32'(dvp_vsync), 32'd1);
        push_frame(int'(pattern_sel), model_fcnt);
        in_frame = 1'b1;
        fs_cyc = cyc;
        lines = 0;
      end
      if (in_frame && !busy) begin
        check("lines_per_frame", 32'(lines), 32'(V_PIXEL));
        check("busy_drop_cycle", 32'(cyc - fs_cyc), 32'(FRAME_LEN));
        in_frame = 1'b0;
      end
      if (dvp_vsync) vs_len++;
      else if (vs_len != 0) begin
        check("vsync_len", 32'(vs_len), 32'(VSYNC_CYC));
        vs_len = 0;
      end
      if (dvp_href) begin
        if (h_len == 0 && lines != 0)
          check("hblank_gap", 32'(cyc - fall_cyc), 32'(H_BLANK));
        h_len++;
        if (exp_q.size() == 0) fail_now("data_unexpected");
        else begin
          exp_b = exp_q.pop_front();
          check("data", 32'(dvp_data), 32'(exp_b));
        end
      end else begin
        if (h_len != 0) begin
          check("href_len", 32'(h_len), 32'(2 * H_PIXEL));
          h_len = 0;
          lines++;
          fall_cyc = cyc;
        end
        check("data_idle_zero", 32'(dvp_data), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_fs(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!frame_start && n < budget);
    if (!frame_start) fail_now(name);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy && n < budget);
    if (busy) fail_now(name);
  endtask

  task automatic pulse_reset();
    sys_rst = 1'b1;
    exp_q.delete();
    model_fcnt = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({dvp_vsync, dvp_href, dvp_data, frame_start, frame_cnt, busy});
  endfunction

  // ---------------- stimulus ----------------
  int fs_before;
  logic [1:0] s0;

  initial begin
    // Reset held, then released with gen_en low.
    repeat (5) @(negedge sys_clk);
    check("reset_outputs", all_outs(), 32'd0);
    sys_rst = 1'b0;
    repeat (100) begin
      @(negedge sys_clk);
      check("idle_outputs", all_outs(), 32'd0);
    end

    // One frame, pixel counter.
    pattern_sel = 2'd1;
    gen_en = 1'b1;
    fs_before = fs_total;
    wait_fs(10, "timeout_fs_counter");
    gen_en = 1'b0;
    wait_idle(FRAME_LEN + 10, "timeout_idle_counter");
    check("frames_counter", 32'(fs_total - fs_before), 32'd1);
    check("frame_cnt_1", 32'(frame_cnt), 32'd1);

    // One frame, colour bars.
    pattern_sel = 2'd0;
    gen_en = 1'b1;
    wait_fs(10, "timeout_fs_bars");
    gen_en = 1'b0;
    wait_idle(FRAME_LEN + 10, "timeout_idle_bars");
    check("frame_cnt_2", 32'(frame_cnt), 32'd2);

    // Three back-to-back tinted frames from a fresh reset.
    pulse_reset();
    pattern_sel = 2'd3;
    gen_en = 1'b1;
    fs_before = fs_total;
    for (int i = 0; i < 3; i++) wait_fs(FRAME_LEN + 5, "timeout_fs_b2b");
    gen_en = 1'b0;
    wait_idle(FRAME_LEN + 10, "timeout_idle_b2b");
    check("frames_b2b", 32'(fs_total - fs_before), 32'd3);
    check("frame_cnt_3", 32'(frame_cnt), 32'd3);

    // gen_en dropped and pattern changed mid-frame.
    s0 = 2'($urandom_range(0, 2));
    pattern_sel = s0;
    gen_en = 1'b1;
    fs_before = fs_total;
    wait_fs(10, "timeout_fs_drop");
    repeat (20) @(negedge sys_clk);
    gen_en = 1'b0;
    pattern_sel = s0 + 2'd1;
    wait_idle(FRAME_LEN + 10, "timeout_idle_drop");
    repeat (5) @(negedge sys_clk);
    check("stays_idle", 32'(busy), 32'd0);
    check("frames_drop", 32'(fs_total - fs_before), 32'd1);

    // Reset during line 2.
    pattern_sel = 2'd1;
    gen_en = 1'b1;
    wait_fs(10, "timeout_fs_rst");
    repeat (50) @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    exp_q.delete();
    model_fcnt = 0;
    #1;
    check("async_reset_outs", all_outs(), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_fs(10, "timeout_fs_after_rst");
    gen_en = 1'b0;
    check("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);
    wait_idle(FRAME_LEN + 10, "timeout_idle_after_rst");

    // Randomised frames: random patterns, mid-frame sel changes, random gaps.
    pattern_sel = 2'($urandom_range(0, 3));
    gen_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_fs(FRAME_LEN + 5, "timeout_fs_random");
      repeat (30 + $urandom_range(0, 20)) @(negedge sys_clk);
      pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        gen_en = 1'b0;
        wait_idle(FRAME_LEN + 10, "timeout_idle_random");
        gen_en = 1'b1;
      end
    end
    gen_en = 1'b0;
    wait_idle(FRAME_LEN + 10, "timeout_idle_final");
    repeat (5) @(negedge sys_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/dvp_pattern_src.md
Name: dvp_pattern_src

Overview:
- Synthesizable DVP source that emulates the OV5640 parallel output in RGB565 mode: vsync, href and 8-bit data, two bytes per pixel, high byte first.
- Drives the camera-capture path (capture → write FIFO → SDRAM → VGA) without a sensor attached. Used for in-system bring-up and as the stimulus generator in capture and SDRAM-path benches.
- Produces selectable test patterns with exact, predictable pixel values so downstream frame contents can be checked word-for-word.

Parameters:
H_PIXEL, 640, active pixels per line (must be a multiple of 8)
V_PIXEL, 480, active lines per frame
H_BLANK, 144, clocks with href low after each active line
VSYNC_CYC, 1600, clocks vsync is held high at frame start
V_BACK_CYC, 3200, clocks between vsync falling and the first href
V_FRONT_CYC, 1600, clocks after the last line's H_BLANK before the next vsync

Ports:
sys_clk  in  1  generator clock; doubles as the pixel clock (one byte per cycle)
sys_rst  in  1  asynchronous, active-high reset
gen_en  in  1  run request; sampled only at frame boundaries
pattern_sel  in  2  0 colour bars, 1 pixel counter, 2 checkerboard, 3 frame-tinted solid
dvp_vsync  out  1  frame sync, active high
dvp_href  out  1  line valid, active high
dvp_data  out  8  RGB565 byte stream
frame_start  out  1  one-cycle pulse coincident with the first vsync-high cycle
frame_cnt  out  16  frames started since reset, wraps at 65535→0
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (sys_clk); reset sys_rst is asynchronous and active-high. All outputs are registered.
- Reset state: every output is 0; FSM in IDLE; all internal counters are 0.
- Reset asserted mid-frame: outputs drop to 0 asynchronously. After release, the FSM restarts from IDLE, with no partial frame resumed.
- FSM states: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT.
  - IDLE: if gen_en=1, go to VSYNC next cycle; latch pattern_sel; pulse frame_start; increment frame_cnt.
  - VSYNC: dvp_vsync=1 for exactly VSYNC_CYC cycles, then VBACK.
  - VBACK: V_BACK_CYC cycles, then LINE.
  - LINE: dvp_href=1 for exactly 2*H_PIXEL cycles, then HBLANK.
  - HBLANK: H_BLANK cycles. If the line counter reaches V_PIXEL-1, go to VFRONT; otherwise go to LINE and increment the line counter.
  - VFRONT: V_FRONT_CYC cycles. Then go to VSYNC if gen_en=1 (same actions as leaving IDLE); otherwise go to IDLE.
- gen_en deassertion mid-frame: the current frame completes. pattern_sel changes mid-frame are ignored.
- Byte order: x = pixel column 0..H_PIXEL-1, y = line 0..V_PIXEL-1. Byte phase 0 outputs pix[15:8]; phase 1 outputs pix[7:0].
- dvp_data is 0 whenever dvp_href=0.
- Patterns:
  - 0 (colour bars): 8 bars of width H_PIXEL/8, generated with a bar counter (no divider). Bar order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1 (pixel counter): 16-bit running pixel index. Cleared at frame start, +1 per pixel, wraps mod 65536, so pix = (y*H_PIXEL + x) mod 65536.
  - 2 (checkerboard): pix = (x[5]^y[5]) ? FFFF : 0000.
  - 3 (frame-tinted solid): pix = {frame_cnt[4:0], 11'd0}, using frame_cnt as updated at this frame's start.
- Frame length in cycles: VSYNC_CYC + V_BACK_CYC + V_PIXEL*(2*H_PIXEL+H_BLANK) + V_FRONT_CYC.
- Back-to-back frames (gen_en held high): the next vsync starts on the cycle after VFRONT ends, with no IDLE cycle.
- Pipeline latency: dvp_data is aligned with dvp_href; the first data byte appears in the same cycle href first goes high.

Test Plan:
(Bench parameters: H_PIXEL=8, V_PIXEL=4, H_BLANK=4, VSYNC_CYC=3, V_BACK_CYC=2, V_FRONT_CYC=2; frame length 87 cycles.)
1. Reset held, then released with gen_en=0 → all outputs remain 0 and busy=0 for 100 cycles.
2. gen_en=1, sel=1, one frame:
   - frame_start pulses once and frame_cnt goes 0→1;
   - vsync is high for 3 cycles;
   - 4 href bursts of 16 cycles each, separated by 4 idle cycles;
   - byte stream line 0 = 00,00,00,01,…,00,07; line 3 ends with 00,1F.
3. sel=0 → each line emits FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
4. gen_en held high for 3 frames:
   - frame_start spacing is exactly 87 cycles;
   - frame_cnt reads 3;
   - sel=3 gives first bytes 08,10,18 in frames 1,2,3.
5. Deassert gen_en at cycle 20 of a frame → that frame finishes all 4 lines, FSM returns to IDLE, busy=0 at cycle 87. Change sel mid-frame → pattern unchanged.
6. Assert sys_rst during line 2 → outputs go to 0 asynchronously. After release with gen_en=1, the next frame starts with frame_cnt=1 and pixel counter 0.
